// File: rtl/intr_ctrl85_if.sv
// Pin, SIM/EI/DI, instruction-boundary and request/ack signals between
// the 8085-style core side and the interrupt controller.
interface intr_ctrl85_if #(
   parameter int ADDRSIZE = 16
);
   logic                trap;
   logic                rst75;
   logic                rst65;
   logic                rst55;
   logic                intr;
   logic                sim_wr;
   logic [7:0]          sim_data;
   logic                ei_set;
   logic                di_set;
   logic                inst_end;
   logic                ack;
   logic                irq;
   logic [2:0]          isrc;
   logic [ADDRSIZE-1:0] ivec;
   logic                ien;
   logic [7:0]          rim_data;

   modport slave (
      input  trap, rst75, rst65, rst55, intr, sim_wr, sim_data,
             ei_set, di_set, inst_end, ack,
      output irq, isrc, ivec, ien, rim_data
   );

   modport master (
      output trap, rst75, rst65, rst55, intr, sim_wr, sim_data,
             ei_set, di_set, inst_end, ack,
      input  irq, isrc, ivec, ien, rim_data
   );
endinterface

// File: rtl/intr_ctrl85.sv
// 8085-style interrupt controller: synchronises pins, applies SIM mask and
// EI/DI, and presents one prioritised restart request at instruction ends.
module intr_ctrl85 #(
   parameter int ADDRSIZE    = 16,
   parameter int SYNC_STAGES = 2
) (
   input logic          clk,
   input logic          rst_,
   intr_ctrl85_if.slave bus
);
   typedef enum logic {IDLE, REQ} state_t;

   localparam int NPIN   = 5;
   localparam int P_TRAP = 4;
   localparam int P_75   = 3;
   localparam int P_65   = 2;
   localparam int P_55   = 1;
   localparam int P_INTR = 0;

   localparam logic [2:0] SRC_TRAP = 3'd0;
   localparam logic [2:0] SRC_75   = 3'd1;
   localparam logic [2:0] SRC_65   = 3'd2;
   localparam logic [2:0] SRC_55   = 3'd3;
   localparam logic [2:0] SRC_INTR = 3'd4;

   localparam logic [ADDRSIZE-1:0] VEC_TRAP = ADDRSIZE'(16'h0024);
   localparam logic [ADDRSIZE-1:0] VEC_75   = ADDRSIZE'(16'h003C);
   localparam logic [ADDRSIZE-1:0] VEC_65   = ADDRSIZE'(16'h0034);
   localparam logic [ADDRSIZE-1:0] VEC_55   = ADDRSIZE'(16'h002C);
   localparam logic [ADDRSIZE-1:0] VEC_INTR = '0;

   logic [SYNC_STAGES-1:0][NPIN-1:0] sync_q;
   logic [NPIN-1:0]     pins, lvl;
   logic [1:0]          dly_q, rise;

   state_t              state_q, state_d;
   logic [2:0]          isrc_q, isrc_d;
   logic [ADDRSIZE-1:0] ivec_q, ivec_d;
   logic                ien_q, ien_d;
   logic                ei_pend_q, ei_pend_d;
   logic [2:0]          mask_q, mask_d;
   logic                trap_lat_q, trap_lat_d;
   logic                r75_q, r75_d;
   logic                ack_acc;
   logic [4:0]          qual;

   assign pins = {bus.trap, bus.rst75, bus.rst65, bus.rst55, bus.intr};
   assign lvl  = sync_q[SYNC_STAGES-1];
   // rise[1] = TRAP edge, rise[0] = RST7.5 edge
   assign rise = lvl[P_TRAP:P_75] & ~dly_q;

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         sync_q <= '0;
         dly_q  <= '0;
      end else begin
         sync_q[0] <= pins;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         dly_q <= lvl[P_TRAP:P_75];
      end
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state_q    <= IDLE;
         isrc_q     <= '0;
         ivec_q     <= '0;
         ien_q      <= 1'b0;
         ei_pend_q  <= 1'b0;
         mask_q     <= 3'b111;
         trap_lat_q <= 1'b0;
         r75_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         isrc_q     <= isrc_d;
         ivec_q     <= ivec_d;
         ien_q      <= ien_d;
         ei_pend_q  <= ei_pend_d;
         mask_q     <= mask_d;
         trap_lat_q <= trap_lat_d;
         r75_q      <= r75_d;
      end
   end

   assign ack_acc = (state_q == REQ) && bus.ack;

   assign qual[0] = trap_lat_q & lvl[P_TRAP];
   assign qual[1] = ien_q & ~mask_q[2] & r75_q;
   assign qual[2] = ien_q & ~mask_q[1] & lvl[P_65];
   assign qual[3] = ien_q & ~mask_q[0] & lvl[P_55];
   assign qual[4] = ien_q & lvl[P_INTR];

   always_comb begin
      state_d    = state_q;
      isrc_d     = isrc_q;
      ivec_d     = ivec_q;
      ien_d      = ien_q;
      ei_pend_d  = ei_pend_q;
      mask_d     = mask_q;
      trap_lat_d = trap_lat_q;
      r75_d      = r75_q;

      // Clears first, so a same-cycle set edge overrides them
      if (ack_acc && isrc_q == SRC_TRAP) trap_lat_d = 1'b0;
      if (rise[1]) trap_lat_d = 1'b1;
      if ((ack_acc && isrc_q == SRC_75) || (bus.sim_wr && bus.sim_data[4]))
         r75_d = 1'b0;
      if (rise[0]) r75_d = 1'b1;

      if (bus.sim_wr && bus.sim_data[3]) mask_d = bus.sim_data[2:0];

      if (bus.di_set || ack_acc) begin
         ien_d     = 1'b0;
         ei_pend_d = 1'b0;
      end else begin
         if (ei_pend_q && bus.inst_end) begin
            ien_d     = 1'b1;
            ei_pend_d = 1'b0;
         end
         if (bus.ei_set) ei_pend_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (bus.inst_end && |qual) begin
               state_d = REQ;
               if (qual[0])      begin isrc_d = SRC_TRAP; ivec_d = VEC_TRAP; end
               else if (qual[1]) begin isrc_d = SRC_75;   ivec_d = VEC_75;   end
               else if (qual[2]) begin isrc_d = SRC_65;   ivec_d = VEC_65;   end
               else if (qual[3]) begin isrc_d = SRC_55;   ivec_d = VEC_55;   end
               else              begin isrc_d = SRC_INTR; ivec_d = VEC_INTR; end
            end
         end
         REQ: if (bus.ack) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign bus.irq      = (state_q == REQ);
   assign bus.isrc     = isrc_q;
   assign bus.ivec     = ivec_q;
   assign bus.ien      = ien_q;
   assign bus.rim_data = {1'b0, r75_q, lvl[P_65], lvl[P_55], ien_q, mask_q};
endmodule

// File: tb/tb_intr_ctrl85.sv
// Directed bench for intr_ctrl85: one task per scenario, inline checks.
module tb_intr_ctrl85;
   logic clk = 1'b0;
   logic rst_;
   int   n_chk = 0;
   int   n_err = 0;

   intr_ctrl85_if #(.ADDRSIZE(16)) bus ();
   intr_ctrl85 #(.ADDRSIZE(16), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst_(rst_), .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic do_sim(input logic [7:0] d);
      bus.sim_wr = 1'b1; bus.sim_data = d; tick(1);
      bus.sim_wr = 1'b0; bus.sim_data = 8'h00;
   endtask

   task automatic do_ei();  bus.ei_set = 1'b1;   tick(1); bus.ei_set = 1'b0;   endtask
   task automatic do_end(); bus.inst_end = 1'b1; tick(1); bus.inst_end = 1'b0; endtask
   task automatic do_ack(); bus.ack = 1'b1;      tick(1); bus.ack = 1'b0;      endtask

   task automatic test_reset();
      rst_ = 1'b0;
      {bus.trap, bus.rst75, bus.rst65, bus.rst55, bus.intr} = '0;
      {bus.sim_wr, bus.ei_set, bus.di_set, bus.inst_end, bus.ack} = '0;
      bus.sim_data = 8'h00;
      tick(2);
      n_chk++; if (bus.irq !== 1'b0) begin n_err++; $display("FAIL rst_irq: got %b exp 0", bus.irq); end
      n_chk++; if (bus.isrc !== 3'd0) begin n_err++; $display("FAIL rst_isrc: got %0d exp 0", bus.isrc); end
      n_chk++; if (bus.ivec !== 16'h0000) begin n_err++; $display("FAIL rst_ivec: got %h exp 0000", bus.ivec); end
      n_chk++; if (bus.rim_data !== 8'h07) begin n_err++; $display("FAIL rst_rim: got %h exp 07", bus.rim_data); end
      rst_ = 1'b1;
      tick(1);
   endtask

   task automatic test_rst75();
      do_sim(8'h08);
      n_chk++; if (bus.rim_data !== 8'h00) begin n_err++; $display("FAIL t1_unmask_rim: got %h exp 00", bus.rim_data); end
      do_ei(); do_end(); do_end();
      n_chk++; if (bus.rim_data !== 8'h08) begin n_err++; $display("FAIL t1_ien_rim: got %h exp 08", bus.rim_data); end
      bus.rst75 = 1'b1; tick(1); bus.rst75 = 1'b0; tick(2);
      n_chk++; if (bus.rim_data !== 8'h48) begin n_err++; $display("FAIL t1_p75_rim: got %h exp 48", bus.rim_data); end
      n_chk++; if (bus.irq !== 1'b0) begin n_err++; $display("FAIL t1_noend_irq: got %b exp 0", bus.irq); end
      do_end();
      n_chk++; if (bus.irq !== 1'b1) begin n_err++; $display("FAIL t1_irq: got %b exp 1", bus.irq); end
      n_chk++; if (bus.isrc !== 3'd1) begin n_err++; $display("FAIL t1_isrc: got %0d exp 1", bus.isrc); end
      n_chk++; if (bus.ivec !== 16'h003C) begin n_err++; $display("FAIL t1_ivec: got %h exp 003c", bus.ivec); end
      do_ack();
      n_chk++; if (bus.irq !== 1'b0) begin n_err++; $display("FAIL t1_ack_irq: got %b exp 0", bus.irq); end
      n_chk++; if (bus.rim_data !== 8'h00) begin n_err++; $display("FAIL t1_ack_rim: got %h exp 00", bus.rim_data); end
   endtask

   task automatic test_priority_65_55();
      do_ei(); do_end();
      bus.rst65 = 1'b1; bus.rst55 = 1'b1; tick(3);
      do_end();
      n_chk++; if (bus.isrc !== 3'd2) begin n_err++; $display("FAIL t2_isrc65: got %0d exp 2", bus.isrc); end
      n_chk++; if (bus.ivec !== 16'h0034) begin n_err++; $display("FAIL t2_ivec65: got %h exp 0034", bus.ivec); end
      tick(2);
      n_chk++; if (bus.irq !== 1'b1) begin n_err++; $display("FAIL t2_hold_irq: got %b exp 1", bus.irq); end
      do_ack(); bus.rst65 = 1'b0;
      n_chk++; if (bus.irq !== 1'b0) begin n_err++; $display("FAIL t2_ack_irq: got %b exp 0", bus.irq); end
      tick(3);
      do_ei(); do_end(); do_end();
      n_chk++; if (bus.isrc !== 3'd3) begin n_err++; $display("FAIL t2_isrc55: got %0d exp 3", bus.isrc); end
      n_chk++; if (bus.ivec !== 16'h002C) begin n_err++; $display("FAIL t2_ivec55: got %h exp 002c", bus.ivec); end
      do_ack(); bus.rst55 = 1'b0; tick(3);
   endtask

   task automatic test_trap();
      do_sim(8'h0F);
      n_chk++; if (bus.rim_data !== 8'h07) begin n_err++; $display("FAIL t3_mask_rim: got %h exp 07", bus.rim_data); end
      bus.trap = 1'b1; tick(3);
      n_chk++; if (bus.irq !== 1'b0) begin n_err++; $display("FAIL t3_noend_irq: got %b exp 0", bus.irq); end
      do_end();
      n_chk++; if (bus.irq !== 1'b1) begin n_err++; $display("FAIL t3_irq: got %b exp 1", bus.irq); end
      n_chk++; if (bus.isrc !== 3'd0) begin n_err++; $display("FAIL t3_isrc: got %0d exp 0", bus.isrc); end
      n_chk++; if (bus.ivec !== 16'h0024) begin n_err++; $display("FAIL t3_ivec: got %h exp 0024", bus.ivec); end
      bus.trap = 1'b0; tick(4);
      n_chk++; if (bus.irq !== 1'b1) begin n_err++; $display("FAIL t3_held_irq: got %b exp 1", bus.irq); end
      n_chk++; if (bus.ivec !== 16'h0024) begin n_err++; $display("FAIL t3_held_ivec: got %h exp 0024", bus.ivec); end
      do_ack();
      n_chk++; if (bus.irq !== 1'b0) begin n_err++; $display("FAIL t3_ack_irq: got %b exp 0", bus.irq); end
      n_chk++; if (dut.trap_lat_q !== 1'b0) begin n_err++; $display("FAIL t3_latch_clr: got %b exp 0", dut.trap_lat_q); end
   endtask

   task automatic test_ei_di_intr();
      bus.ei_set = 1'b1; bus.di_set = 1'b1; tick(1);
      bus.ei_set = 1'b0; bus.di_set = 1'b0;
      bus.intr = 1'b1; tick(3);
      do_end();
      n_chk++; if (bus.ien !== 1'b0) begin n_err++; $display("FAIL t4_eidi_ien: got %b exp 0", bus.ien); end
      n_chk++; if (bus.irq !== 1'b0) begin n_err++; $display("FAIL t4_eidi_irq: got %b exp 0", bus.irq); end
      do_end();
      n_chk++; if (bus.ien !== 1'b0) begin n_err++; $display("FAIL t4_eidi_ien2: got %b exp 0", bus.ien); end
      do_ei(); do_end();
      n_chk++; if (bus.ien !== 1'b1) begin n_err++; $display("FAIL t4_ei_ien: got %b exp 1", bus.ien); end
      n_chk++; if (bus.irq !== 1'b0) begin n_err++; $display("FAIL t4_ei_irq: got %b exp 0", bus.irq); end
      do_end();
      n_chk++; if (bus.irq !== 1'b1) begin n_err++; $display("FAIL t4_intr_irq: got %b exp 1", bus.irq); end
      n_chk++; if (bus.isrc !== 3'd4) begin n_err++; $display("FAIL t4_intr_isrc: got %0d exp 4", bus.isrc); end
      n_chk++; if (bus.ivec !== 16'h0000) begin n_err++; $display("FAIL t4_intr_ivec: got %h exp 0000", bus.ivec); end
      do_ack(); bus.intr = 1'b0; tick(3);
   endtask

   task automatic test_r75_clear();
      bus.rst75 = 1'b1; tick(1); bus.rst75 = 1'b0; tick(2);
      n_chk++; if (bus.rim_data !== 8'h47) begin n_err++; $display("FAIL t5_latch_rim: got %h exp 47", bus.rim_data); end
      do_sim(8'h10);
      n_chk++; if (bus.rim_data !== 8'h07) begin n_err++; $display("FAIL t5_clr_rim: got %h exp 07", bus.rim_data); end
      // Edge reaches the latch on the same clock as the SIM clear
      bus.rst75 = 1'b1; tick(1); bus.rst75 = 1'b0; tick(1);
      do_sim(8'h10);
      n_chk++; if (bus.rim_data !== 8'h47) begin n_err++; $display("FAIL t5_setwins_rim: got %h exp 47", bus.rim_data); end
      do_sim(8'h10);
      n_chk++; if (bus.rim_data !== 8'h07) begin n_err++; $display("FAIL t5_clr2_rim: got %h exp 07", bus.rim_data); end
   endtask

   task automatic test_reset_midreq();
      do_sim(8'h08); do_ei(); do_end();
      bus.rst55 = 1'b1; tick(3);
      do_end();
      n_chk++; if (bus.isrc !== 3'd3) begin n_err++; $display("FAIL t6_pre_isrc: got %0d exp 3", bus.isrc); end
      n_chk++; if (bus.irq !== 1'b1) begin n_err++; $display("FAIL t6_pre_irq: got %b exp 1", bus.irq); end
      rst_ = 1'b0; #1;
      n_chk++; if (bus.irq !== 1'b0) begin n_err++; $display("FAIL t6_rst_irq: got %b exp 0", bus.irq); end
      n_chk++; if (bus.ien !== 1'b0) begin n_err++; $display("FAIL t6_rst_ien: got %b exp 0", bus.ien); end
      n_chk++; if (bus.isrc !== 3'd0) begin n_err++; $display("FAIL t6_rst_isrc: got %0d exp 0", bus.isrc); end
      n_chk++; if (bus.rim_data !== 8'h07) begin n_err++; $display("FAIL t6_rst_rim: got %h exp 07", bus.rim_data); end
      rst_ = 1'b1; tick(4);
      n_chk++; if (bus.irq !== 1'b0) begin n_err++; $display("FAIL t6_post_irq: got %b exp 0", bus.irq); end
      do_end();
      n_chk++; if (bus.irq !== 1'b0) begin n_err++; $display("FAIL t6_post_end_irq: got %b exp 0", bus.irq); end
      bus.rst55 = 1'b0; tick(2);
   endtask

   initial begin
      test_reset();
      test_rst75();
      test_priority_65_55();
      test_trap();
      test_ei_di_intr();
      test_r75_clear();
      test_reset_midreq();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end
endmodule
